// File: rtl/mips_pkg.sv
// Shared pipeline definitions: reset constants, IF-stage state encoding and
// the IF/ID bundle field widths used by both the fetch and decode stages.
package mips_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int unsigned IF_ID_INSTR_W = 32;
  localparam int unsigned IF_ID_PC_W    = 32;
  localparam int unsigned IF_ID_VALID_W = 1;

  typedef enum logic {
    StBoot = 1'b0,
    StRun  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous flush (bubble) beats hold (stall);
// asynchronous active-low reset loads a bubble.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NopWord = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic [IF_ID_INSTR_W-1:0] instr_i,
  input  logic [IF_ID_PC_W-1:0]    pc_plus4_i,
  input  logic [IF_ID_VALID_W-1:0] valid_i,
  output logic [IF_ID_INSTR_W-1:0] instr_o,
  output logic [IF_ID_PC_W-1:0]    pc_plus4_o,
  output logic [IF_ID_VALID_W-1:0] valid_o
);

  logic [IF_ID_INSTR_W-1:0] instr_d, instr_q;
  logic [IF_ID_PC_W-1:0]    pc_plus4_d, pc_plus4_q;
  logic [IF_ID_VALID_W-1:0] valid_d, valid_q;

  always_comb begin
    instr_d    = instr_i;
    pc_plus4_d = pc_plus4_i;
    valid_d    = valid_i;
    if (flush_i) begin
      instr_d    = NopWord;
      pc_plus4_d = '0;
      valid_d    = '0;
    end else if (hold_i) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= NopWord;
      pc_plus4_q <= '0;
      valid_q    <= '0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// fills IF/ID, with branch > jump > stall redirect priority.
module if_stage #(
  parameter logic [31:0] RESET_PC        = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD        = mips_pkg::NOP_WORD,
  parameter int unsigned IMEM_WORDS_LOG2 = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount,
  output logic        AddrOutOfRange
);
  import mips_pkg::*;

  if_state_e   state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] count_d, count_q;
  logic [31:0] pc_plus4;
  logic        flush, hold;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = StRun;
    pc_d    = pc_q;
    count_d = count_q;
    flush   = 1'b0;
    hold    = 1'b0;
    if (state_q == StBoot) begin
      // Settle cycle for the memory after reset: PC held, bubble into IF/ID.
      flush = 1'b1;
    end else if (BranchTaken) begin
      pc_d  = BranchTarget & ~32'd3;
      flush = 1'b1;
    end else if (Jump) begin
      pc_d  = JumpTarget & ~32'd3;
      flush = 1'b1;
    end else if (Stall) begin
      hold = 1'b1;
    end else begin
      pc_d    = pc_plus4;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC & ~32'd3;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .NopWord(NOP_WORD)
  ) u_if_id_reg (
    .clk_i     (Clk),
    .rst_ni    (Rst),
    .hold_i    (hold),
    .flush_i   (flush),
    .instr_i   (IMemInstruction),
    .pc_plus4_i(pc_plus4),
    .valid_i   (1'b1),
    .instr_o   (IF_ID_Instruction),
    .pc_plus4_o(IF_ID_PCPlus4),
    .valid_o   (IF_ID_Valid)
  );

  assign IMemAddress    = {pc_q[31:2], 2'b00};
  assign FetchCount     = count_q;
  assign AddrOutOfRange = |pc_q[31:IMEM_WORDS_LOG2+2];

endmodule
